// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage: condition encodings,
// NZCV bit positions and FlagW bit positions.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides from the registered NZCV
// flags whether the instruction carrying the given condition field executes.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_s, z_s, c_s, v_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Condition-code decode against the current flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_CC: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = (n_s == v_s);
            COND_LT: cond_ex = (n_s != v_s);
            COND_GT: cond_ex = ~z_s & (n_s == v_s);
            COND_LE: cond_ex = z_s | (n_s != v_s);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, write-enable gating and,
// when COND_STATS_EN is defined, executed/squashed retire counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int         CNT_W     = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt,
`endif
    output logic [3:0]       Flags
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_s;
    logic       commit_s;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex_s)
    );

    assign commit_s = en & cond_ex_s;

    // Each flag half is written independently, and only by an executing instruction
    always_comb begin
        flags_d = flags_q;
        if (commit_s) begin
            if (FlagW[FLAGW_NZ]) begin
                flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
            end else begin
                flags_d[FLAG_N:FLAG_Z] = flags_q[FLAG_N:FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
            end else begin
                flags_d[FLAG_C:FLAG_V] = flags_q[FLAG_C:FLAG_V];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // Flag register; reset wins over any retiring instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign CondEx   = cond_ex_s;
    assign PCSrc    = PCS  & cond_ex_s;
    assign RegWrite = RegW & cond_ex_s;
    assign MemWrite = MemW & cond_ex_s;
    assign Flags    = flags_q;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Every retiring instruction bumps exactly one of the two counters
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (en) begin
            if (cond_ex_s) begin
                exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end else begin
                squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end else begin
            exec_cnt_d   = exec_cnt_q;
            squash_cnt_d = squash_cnt_q;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ExecCnt   = exec_cnt_q;
    assign SquashCnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed, table-driven bench for cond_unit; counter checks are enabled
// when COND_STATS_EN is defined.
module tb_cond_unit;

    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] ExecCnt, SquashCnt;
    int exp_exec = 0;
    int exp_squash = 0;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       ce;
        logic [3:0] flags_after;
    } vec_t;

    vec_t vecs[$];

    cond_unit #(.CNT_W(CNT_W), .FLAGS_RST(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
`ifdef COND_STATS_EN
        .ExecCnt  (ExecCnt),
        .SquashCnt(SquashCnt),
`endif
        .Flags    (Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] c, input logic [3:0] a, input logic [1:0] f,
                       input logic p, input logic r, input logic m, input logic ce,
                       input logic [3:0] fa);
        vec_t v;
        v = '{en: e, cond: c, alu: a, fw: f, pcs: p, regw: r, memw: m, ce: ce, flags_after: fa};
        vecs.push_back(v);
    endtask

    // Drive one instruction (called just after a posedge), check combinational
    // outputs mid-cycle, then check flags after the edge.
    task automatic step(input string tag, input logic rst, input logic e, input logic [3:0] c,
                        input logic [3:0] a, input logic [1:0] f, input logic p,
                        input logic r, input logic m, input logic chk_comb, input logic ce,
                        input logic [3:0] fa);
        reset = rst; en = e; Cond = c; ALUFlags = a; FlagW = f; PCS = p; RegW = r; MemW = m;
        #4;
        if (chk_comb) begin
            chk({tag, ".CondEx"},   32'(CondEx),   32'(ce));
            chk({tag, ".PCSrc"},    32'(PCSrc),    32'(p & ce));
            chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(r & ce));
            chk({tag, ".MemWrite"}, 32'(MemWrite), 32'(m & ce));
        end
`ifdef COND_STATS_EN
        if (rst) begin
            exp_exec = 0; exp_squash = 0;
        end else if (e) begin
            if (ce) exp_exec++;
            else    exp_squash++;
        end
`endif
        @(posedge clk);
        #1;
        chk({tag, ".Flags"}, 32'(Flags), 32'(fa));
`ifdef COND_STATS_EN
        chk({tag, ".ExecCnt"},   ExecCnt,   32'(exp_exec));
        chk({tag, ".SquashCnt"}, SquashCnt, 32'(exp_squash));
`endif
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

        //   en cond     alu      fw     pcs   regw  memw  ce    flags_after
        add(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000); // EQ, Z=0
        add(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100); // AL writes Z
        add(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100); // EQ sees Z
        add(1'b1, 4'b0001, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100); // NE squashed
        add(1'b1, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000); // NZ only
        add(1'b1, 4'b1110, 4'b0001, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001); // CV only
        add(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // GT
        add(1'b1, 4'b1101, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001); // LE squashed
        add(1'b0, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001); // stall
        add(1'b1, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // MI
        add(1'b1, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001); // PL
        add(1'b1, 4'b0110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // VS
        add(1'b1, 4'b0111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001); // VC
        add(1'b1, 4'b0010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001); // CS
        add(1'b1, 4'b0011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // CC
        add(1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001); // HI
        add(1'b1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // LS
        add(1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001); // GE
        add(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001); // LT
        add(1'b1, 4'b1111, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001); // NV holds flags
        add(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110); // Z=1,C=1
        add(1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110); // HI
        add(1'b1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110); // LS
        add(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110); // GT
        add(1'b1, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110); // LE
        add(1'b1, 4'b0010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110); // CS
        add(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000); // EQ uses old Z
        add(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000); // new Z visible
        add(1'b0, 4'b0001, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000); // stall, NE

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset.Flags", 32'(Flags), 32'h0);
`ifdef COND_STATS_EN
        chk("reset.ExecCnt",   ExecCnt,   32'h0);
        chk("reset.SquashCnt", SquashCnt, 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), 1'b0, vecs[i].en, vecs[i].cond, vecs[i].alu, vecs[i].fw,
                 vecs[i].pcs, vecs[i].regw, vecs[i].memw, 1'b1, vecs[i].ce, vecs[i].flags_after);
        end

        // Mid-stream reset overrides an executing flag write
        step("pre_rst", 1'b0, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        step("mid_rst", 1'b1, 1'b1, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step("post_rst", 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);

        // Three executed and two squashed retires from a clean reset
        step("cnt_rst", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        step("cnt_e0", 1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        step("cnt_s0", 1'b0, 1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        step("cnt_e1", 1'b0, 1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
        step("cnt_s1", 1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        step("cnt_e2", 1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
`ifdef COND_STATS_EN
        chk("cnt.ExecCnt3",   ExecCnt,   32'd3);
        chk("cnt.SquashCnt2", SquashCnt, 32'd2);
`endif
        step("cnt_clr", 1'b1, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
